if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage and producer side of the IF/ID pipeline latch. It owns the fetch PC,
//  drives a req/ack instruction-memory port and buffers fetched {pc, instr} pairs in a 2-entry queue.
//  It presents the queue head as PCOUT/IR to the IF/ID latch and obeys that latch's stall and flush rules.
//  Branch and jump redirects come from EX. Memory latency is variable, from 0 to N wait cycles.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset
//  NOP_INSTR 32'h0000_0013  instruction presented when the queue is empty (addi x0,x0,0)
//  QDEPTH    2              fetch-queue entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  en           in   1   pipeline enable; pop and redirect take effect only when en=1
//  stall_if     in   1   data-hazard stall; IF/ID holds its value, so no pop this cycle
//  redirect     in   1   branch/jump taken; flush the queue and restart fetch
//  redirect_pc  in   32  new fetch address; bits [1:0] ignored and forced to 0
//  imem_req     out  1   instruction-memory request
//  imem_addr    out  32  request address; stable while imem_req=1 and imem_ack=0
//  imem_ack     in   1   request completes on a cycle where req&ack; may be same-cycle as req
//  imem_rdata   in   32  instruction; valid only on a req&ack cycle
//  pc_if        out  32  PC of queue head; 32'h0 when empty (to IF/ID PCOUT)
//  ir_if        out  32  instruction at queue head; NOP_INSTR when empty (to IF/ID IR)
//  if_valid     out  1   queue non-empty
// BEHAVIOUR
//  Reset (async)
//   - fetch_pc=RESET_PC, state=FETCH, queue count=0.
//   - Outputs: imem_req=0 while rst=1, pc_if=0, ir_if=NOP_INSTR, if_valid=0.
//  Outputs
//   - pc_if, ir_if and if_valid are combinational from the registered queue head.
//   - No latency is added beyond the queue.
//  FSM
//   - FETCH: imem_req=(count<QDEPTH); imem_addr=fetch_pc.
//       On req&ack: push {fetch_pc, imem_rdata}; fetch_pc += 4, mod 2^32 (wraps 0xFFFF_FFFC -> 0).
//   - DROP: imem_req=1; imem_addr=drop_addr.
//       On ack: discard imem_rdata; go to FETCH.
//  Pop
//   - Pops when en & ~stall_if & ~redirect & if_valid. One entry per cycle.
//  Redirect (en=1 & redirect)
//   - Priority over stall_if and over pop.
//   - Queue cleared; fetch_pc <= {redirect_pc[31:2], 2'b00}.
//   - In FETCH with req & ~ack: drop_addr <= old fetch_pc; go to DROP (one outstanding request max).
//   - In FETCH with req & ack the same cycle: returned data discarded (no push); stay in FETCH.
//   - In DROP: only fetch_pc is updated; stay in DROP until ack.
//  en=0
//   - No pop and no redirect. Memory handshake still proceeds: pushes and DROP completion continue.
//  Boundary conditions
//   - Push and pop in the same cycle: count unchanged.
//   - Pop and redirect in the same cycle: redirect wins.
//   - count==QDEPTH forces imem_req=0. req never deasserts while an ack is pending,
//     because count only grows on ack.
//   - Redirect on the cycle after reset release is legal.
//   - Reset mid-request returns to the reset state. The memory model must tolerate an abandoned request.
// TESTING
//  1. Reset release, ack always 1
//     -> imem_addr 0x0, 0x4 on successive cycles.
//     -> pc_if/ir_if follow the imem contents; if_valid=1 from the 2nd cycle.
//  2. Queue full with stall_if=1
//     -> imem_req=0, count=2, pc_if held at 0x0.
//     -> stall_if=0 pops one per cycle: 0x0, 0x4, 0x8.
//  3. ack delayed 3 cycles at addr 0x8; redirect to 0x100 in the 1st wait cycle
//     -> DROP, imem_addr stays 0x8, data discarded.
//     -> Next request at 0x100; if_valid=0 until it returns.
//  4. redirect and req&ack in the same cycle (addr 0xC, redirect_pc 0x203)
//     -> no push; next imem_addr=0x200.
//  5. en=0 for 4 cycles with ack=1
//     -> queue fills to 2, then imem_req=0, head unchanged, no pop; redirect=1 during en=0 ignored.
//  6. fetch_pc=0xFFFF_FFFC, ack=1
//     -> next imem_addr=0x0.
//  7. rst asserted mid-DROP
//     -> imem_req=0 immediately; after release, first request at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a req/ack imem port and
// buffers fetched {pc, instr} pairs in a small queue feeding the IF/ID latch.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          QDEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        stall_if,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_if,
   output logic [31:0] ir_if,
   output logic        if_valid
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   drop_addr_q, drop_addr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   pc_mem_q [QDEPTH];
   logic [31:0]   pc_mem_d [QDEPTH];
   logic [31:0]   ir_mem_q [QDEPTH];
   logic [31:0]   ir_mem_d [QDEPTH];

   logic          do_redirect;
   logic          handshake;
   logic          push;
   logic          pop;
   logic          room;

   assign room        = (count_q < FULL_COUNT);
   assign do_redirect = en & redirect;
   assign if_valid    = (count_q != '0);

   // Requests are gated by rst so the port is quiet for the whole reset pulse.
   assign imem_req  = ~rst & ((state_q == DROP) | room);
   assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
   assign handshake = imem_req & imem_ack;

   // A redirect beats both the push of same-cycle data and the pop.
   assign push = (state_q == FETCH) & handshake & ~do_redirect;
   assign pop  = en & ~stall_if & ~redirect & if_valid;

   assign pc_if = if_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
   assign ir_if = if_valid ? ir_mem_q[rd_ptr_q] : NOP_INSTR;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;

      if (do_redirect) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end

      case (state_q)
         FETCH: begin
            // An in-flight request cannot be withdrawn, so its answer is
            // swallowed in DROP before fetching from the new target.
            if (do_redirect && imem_req && !imem_ack) begin
               state_d     = DROP;
               drop_addr_d = fetch_pc_q;
            end
         end
         DROP: begin
            if (imem_ack) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= RESET_PC;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
         always_comb begin
            pc_mem_d[gi] = pc_mem_q[gi];
            ir_mem_d[gi] = ir_mem_q[gi];
            if (push && (wr_ptr_q == PW'(gi))) begin
               pc_mem_d[gi] = fetch_pc_q;
               ir_mem_d[gi] = imem_rdata;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pc_mem_q[gi] <= 32'h0;
               ir_mem_q[gi] <= NOP_INSTR;
            end else begin
               pc_mem_q[gi] <= pc_mem_d[gi];
               ir_mem_q[gi] <= ir_mem_d[gi];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle-stepped stimulus with inline port
// checks, plus a scoreboard monitor that checks every entry the stage pops.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic        stall_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_if;
   logic [31:0] ir_if;
   logic        if_valid;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
   } entry_t;

   entry_t exp_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   if_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .stall_if    (stall_if),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc_if       (pc_if),
      .ir_if       (ir_if),
      .if_valid    (if_valid)
   );

   // Memory content is the address tagged with a fixed pattern.
   assign imem_rdata = imem_addr ^ 32'hCAFE_0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_pop(input logic [31:0] pc, input logic [31:0] ir);
      entry_t e;
      e.pc = pc;
      e.ir = ir;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples late in the cycle and checks each popped head.
   initial begin
      entry_t e;
      forever begin
         @(posedge clk);
         #8;
         if (!rst && en && !stall_if && !redirect && if_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got pc %h, expected no pop", pc_if);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", pc_if, e.pc);
               check("pop_ir", ir_if, e.ir);
               $display("[TB] pop pc=%h ir=%h", pc_if, ir_if);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; stall_if = 1'b1; redirect = 1'b0;
      redirect_pc = 32'h0; imem_ack = 1'b0;

      cyc();
      check("rst_req",   {31'h0, imem_req}, 32'h0);
      check("rst_pc",    pc_if, 32'h0);
      check("rst_ir",    ir_if, NOP);
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      cyc();
      rst = 1'b0;

      // Reset release with ack always high, stalled so the queue fills.
      imem_ack = 1'b1; #7;
      check("a_addr",  imem_addr, 32'h0);
      check("a_req",   {31'h0, imem_req}, 32'h1);
      check("a_valid", {31'h0, if_valid}, 32'h0);
      cyc(); #7;
      check("b_addr",  imem_addr, 32'h4);
      check("b_valid", {31'h0, if_valid}, 32'h1);
      check("b_pc",    pc_if, 32'h0);
      check("b_ir",    ir_if, 32'hCAFE_0000);
      cyc(); #7;
      check("c_req_full", {31'h0, imem_req}, 32'h0);
      check("c_pc_held",  pc_if, 32'h0);

      // Release the stall: pops 0x0, 0x4, 0x8 one per cycle.
      cyc();
      expect_pop(32'h0, 32'hCAFE_0000);
      expect_pop(32'h4, 32'hCAFE_0004);
      expect_pop(32'h8, 32'hCAFE_0008);
      stall_if = 1'b0; #7;
      check("d_req", {31'h0, imem_req}, 32'h0);
      cyc(); #7;
      check("e_addr", imem_addr, 32'h8);
      check("e_pc",   pc_if, 32'h4);
      cyc();
      imem_ack = 1'b0; #7;
      check("f_pc",   pc_if, 32'h8);
      check("f_addr", imem_addr, 32'hC);

      // Slow ack at 0xC with a redirect to 0x100 while it is outstanding.
      cyc();
      stall_if = 1'b1; redirect = 1'b1; redirect_pc = 32'h100; #7;
      check("g_addr",  imem_addr, 32'hC);
      check("g_valid", {31'h0, if_valid}, 32'h0);
      cyc();
      redirect = 1'b0; #7;
      check("h_req",  {31'h0, imem_req}, 32'h1);
      check("h_drop_addr", imem_addr, 32'hC);
      cyc();
      imem_ack = 1'b1; #7;
      check("i_drop_addr", imem_addr, 32'hC);
      cyc();
      imem_ack = 1'b0; #7;
      check("j_addr",  imem_addr, 32'h100);
      check("j_valid", {31'h0, if_valid}, 32'h0);
      cyc();
      imem_ack = 1'b1; #7;
      check("k_addr", imem_addr, 32'h100);

      // Redirect coinciding with a completed request: no push.
      cyc();
      redirect = 1'b1; redirect_pc = 32'h203; #7;
      check("l_pc",   pc_if, 32'h100);
      check("l_addr", imem_addr, 32'h104);
      cyc();
      redirect = 1'b0; imem_ack = 1'b0; #7;
      check("m_addr",  imem_addr, 32'h200);
      check("m_valid", {31'h0, if_valid}, 32'h0);

      // en low for four cycles: fills, no pop, redirect ignored.
      cyc();
      en = 1'b0; imem_ack = 1'b1; stall_if = 1'b0; redirect = 1'b1; redirect_pc = 32'h400; #7;
      check("n_addr", imem_addr, 32'h200);
      cyc(); #7;
      check("o_addr", imem_addr, 32'h204);
      check("o_pc",   pc_if, 32'h200);
      cyc(); #7;
      check("p_req", {31'h0, imem_req}, 32'h0);
      check("p_pc",  pc_if, 32'h200);
      cyc(); #7;
      check("q_req",   {31'h0, imem_req}, 32'h0);
      check("q_valid", {31'h0, if_valid}, 32'h1);
      check("q_pc",    pc_if, 32'h200);
      cyc();
      en = 1'b1; redirect = 1'b0; imem_ack = 1'b0;
      expect_pop(32'h200, 32'hCAFE_0200);
      expect_pop(32'h204, 32'hCAFE_0204);
      #7;
      check("r_pc", pc_if, 32'h200);
      cyc(); #7;
      check("s_pc",   pc_if, 32'h204);
      check("s_addr", imem_addr, 32'h208);

      // Wrap of the fetch PC past the top of the address space.
      cyc();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; stall_if = 1'b1; #7;
      check("t_valid", {31'h0, if_valid}, 32'h0);
      check("t_addr",  imem_addr, 32'h208);
      cyc();
      redirect = 1'b0; #7;
      check("u_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(); #7;
      check("v_addr_wrap", imem_addr, 32'h0);
      check("v_pc", pc_if, 32'hFFFF_FFFC);
      cyc();
      imem_ack = 1'b0; stall_if = 1'b0;
      expect_pop(32'hFFFF_FFFC, 32'h3501_FFFC);
      expect_pop(32'h0, 32'hCAFE_0000);
      #7;
      check("w_req", {31'h0, imem_req}, 32'h0);
      cyc(); #7;
      check("x_pc",   pc_if, 32'h0);
      check("x_addr", imem_addr, 32'h4);

      // Enter DROP, then reset in the middle of it.
      cyc();
      stall_if = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; #7;
      check("y_valid", {31'h0, if_valid}, 32'h0);
      cyc();
      redirect = 1'b0; #7;
      check("z_drop_addr", imem_addr, 32'h4);
      rst = 1'b1; #1;
      check("z_rst_req", {31'h0, imem_req}, 32'h0);
      cyc();
      rst = 1'b0; #7;
      check("post_rst_addr",  imem_addr, 32'h0);
      check("post_rst_req",   {31'h0, imem_req}, 32'h1);
      check("post_rst_valid", {31'h0, if_valid}, 32'h0);
      cyc();
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
